// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 32-bit UART TX controller between NUM_REQ word sources.
// Each granted packet is framed as header, payload words, trailer (count + timeout flag).
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [NUM_REQ-1:0]      grant,
  input  logic                    tx_ready,
  output logic [31:0]             tx_data,
  output logic                    tx_strobe,
  output logic                    busy,
  output logic                    timeout_pulse,
  output logic [1:0]              dbg_state
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_TRL  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                holdoff_q, holdoff_d;
  logic [31:0]         tx_data_q, tx_data_d;
  logic                tx_strobe_q, tx_strobe_d;
  logic                timeout_pulse_q, timeout_pulse_d;

  logic [IW-1:0]       arb_idx;
  logic [IW-1:0]       cand;
  logic                arb_found;
  logic                issue;
  logic                cur_valid;
  logic                cur_last;
  logic [31:0]         cur_data;
  logic [1:0]          id;
  logic                tmo_hit;

  // Handshake: a word moves to the controller only when tx_ready=1 and holdoff=0; the
  // controller's ready is registered, so holdoff masks the edge right after each strobe.
  assign issue     = tx_ready & ~holdoff_q;
  assign id        = 2'(ptr_q);
  assign cur_valid = req_valid[ptr_q];
  assign cur_last  = req_last[ptr_q];
  assign cur_data  = req_data[32*int'(ptr_q) +: 32];
  assign tmo_hit   = (tmo_q == 16'(TIMEOUT - 1));

  // Search starts one past the last owner so every source gets its turn.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      ptr_q           <= IW'(NUM_REQ - 1);
      grant_q         <= '0;
      req_ack_q       <= '0;
      cnt_q           <= 16'd0;
      tmo_q           <= 16'd0;
      err_q           <= 1'b0;
      holdoff_q       <= 1'b0;
      tx_data_q       <= 32'd0;
      tx_strobe_q     <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      grant_q         <= grant_d;
      req_ack_q       <= req_ack_d;
      cnt_q           <= cnt_d;
      tmo_q           <= tmo_d;
      err_q           <= err_d;
      holdoff_q       <= holdoff_d;
      tx_data_q       <= tx_data_d;
      tx_strobe_q     <= tx_strobe_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (arb_found) state_d = S_HDR;
      S_HDR:  if (issue) state_d = S_DATA;
      S_DATA: begin
        if (cur_valid) begin
          if (issue && cur_last) state_d = S_TRL;
        end else if (tmo_hit) begin
          state_d = S_TRL;
        end
      end
      S_TRL:  if (issue) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d           = ptr_q;
    grant_d         = grant_q;
    cnt_d           = cnt_q;
    tmo_d           = tmo_q;
    err_d           = err_q;
    holdoff_d       = 1'b0;
    tx_data_d       = tx_data_q;
    tx_strobe_d     = 1'b0;
    req_ack_d       = '0;
    timeout_pulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          ptr_d          = arb_idx;
          grant_d        = '0;
          grant_d[arb_idx] = 1'b1;
          cnt_d          = 16'd0;
          tmo_d          = 16'd0;
        end
      end
      S_HDR: begin
        if (issue) begin
          tx_data_d   = {8'hA5, 6'd0, id, 16'h0000};
          tx_strobe_d = 1'b1;
          holdoff_d   = 1'b1;
        end
      end
      S_DATA: begin
        // A waiting word stalls the timeout; only an absent word counts toward it.
        if (cur_valid) begin
          if (issue) begin
            tx_data_d   = cur_data;
            tx_strobe_d = 1'b1;
            holdoff_d   = 1'b1;
            req_ack_d   = grant_q;
            tmo_d       = 16'd0;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end
        end else if (tmo_hit) begin
          tmo_d           = 16'(TIMEOUT);
          err_d           = 1'b1;
          timeout_pulse_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_TRL: begin
        if (issue) begin
          tx_data_d   = {8'h5A, err_q, 5'd0, id, cnt_q};
          tx_strobe_d = 1'b1;
          holdoff_d   = 1'b1;
          grant_d     = '0;
          err_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign req_ack       = req_ack_q;
  assign grant         = grant_q;
  assign tx_data       = tx_data_q;
  assign tx_strobe     = tx_strobe_q;
  assign timeout_pulse = timeout_pulse_q;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-source packet memories, a UART ready model, and a
// scoreboard that checks every strobe against hand-computed expected words and acks.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [32*N-1:0]   req_data  = '0;
  logic [N-1:0]      req_last  = '0;
  logic [N-1:0]      req_ack;
  logic [N-1:0]      grant;
  logic              tx_ready = 1'b1;
  logic [31:0]       tx_data;
  logic              tx_strobe;
  logic              busy;
  logic              timeout_pulse;
  logic [1:0]        dbg_state;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ack       (req_ack),
    .grant         (grant),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_strobe     (tx_strobe),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .dbg_state     (dbg_state)
  );

  // ---------------- shared state ----------------
  int           vectors    = 0;
  int           miscompares = 0;
  int           cyc        = 0;
  logic [31:0]  exp_q[$];
  logic [N-1:0] exp_ack_q[$];
  logic [32:0]  mem [N][16];
  int           len [N] = '{default: 0};
  int           pos [N] = '{default: 0};
  int           ack_cnt [N] = '{default: 0};
  int           ack_cyc [N] = '{default: 0};
  int           tmo_count = 0;
  int           tmo_cyc   = 0;
  logic         prev_strobe = 1'b0;
  logic         ready_tied  = 1'b0;
  int           rdy_cnt     = 0;
  logic [31:0]  mon_e;
  logic [N-1:0] mon_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_word(input int src, input logic [31:0] data, input logic last);
    mem[src][len[src]] = {last, data};
    len[src]++;
  endtask

  task automatic expect_word(input logic [31:0] data, input logic [N-1:0] ack);
    exp_q.push_back(data);
    exp_ack_q.push_back(ack);
  endtask

  task automatic expect_packet(input int src, input logic [31:0] d[], input logic err);
    expect_word(32'hA5000000 | (32'(src) << 16), '0);
    foreach (d[k]) expect_word(d[k], N'(1) << src);
    expect_word({8'h5A, err, 5'd0, 2'(src), 16'(d.size())}, '0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_ack_q.delete();
    repeat (4) @(negedge clk);
    #1;
    check({name, "_grant_idle"}, 32'(grant), 32'd0);
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_ack(input int src, input int target);
    int n = 0;
    while (ack_cnt[src] < target && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("ack_wait", 32'(ack_cnt[src] >= target), 32'd1);
  endtask

  // ---------------- source and UART ready models ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      tx_ready = 1'b1;
      rdy_cnt  = 0;
    end else if (ready_tied) begin
      tx_ready = 1'b1;
    end else if (tx_strobe) begin
      tx_ready = 1'b0;
      rdy_cnt  = 8;
    end else if (rdy_cnt > 0) begin
      rdy_cnt--;
      if (rdy_cnt == 0) tx_ready = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (!reset_n) pos[i] = len[i];
      else if (req_valid[i] && req_ack[i]) pos[i]++;
      if (pos[i] < len[i]) begin
        req_valid[i]          = 1'b1;
        req_data[32*i +: 32]  = mem[i][pos[i]][31:0];
        req_last[i]           = mem[i][pos[i]][32];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[32*i +: 32]  = '0;
        req_last[i]           = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (tx_strobe) begin
        check("strobe_spacing", 32'(prev_strobe), 32'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: got %h expected no strobe", tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = exp_ack_q.pop_front();
          check("tx_data", tx_data, mon_e);
          check("req_ack", 32'(req_ack), 32'(mon_a));
        end
      end else if (req_ack != '0) begin
        check("ack_without_strobe", 32'(req_ack), 32'd0);
      end
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          ack_cnt[i]++;
          ack_cyc[i] = cyc;
        end
      end
      if (timeout_pulse) begin
        tmo_count++;
        tmo_cyc = cyc;
      end
    end
    prev_strobe = tx_strobe;
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] d[];
    int base;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_tx_strobe", 32'(tx_strobe), 32'd0);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout_pulse), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Round-robin: two one-word packets per source, all queued at once.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        add_word(i, 32'h0BAD0000 | (32'(r) << 8) | 32'(i), 1'b1);
        d = new[1];
        d[0] = 32'h0BAD0000 | (32'(r) << 8) | 32'(i);
        expect_packet(i, d, 1'b0);
      end
    end
    wait_drain("round_robin");

    // Single source, two words.
    base = ack_cnt[0];
    add_word(0, 32'h11223344, 1'b0);
    add_word(0, 32'h55667788, 1'b1);
    expect_word(32'hA5000000, 4'b0000);
    expect_word(32'h11223344, 4'b0001);
    expect_word(32'h55667788, 4'b0001);
    expect_word(32'h5A000002, 4'b0000);
    wait_drain("single");
    check("single_ack_count", 32'(ack_cnt[0] - base), 32'd2);

    // No preemption: req2 arrives during req1's three-word packet.
    base = ack_cnt[1];
    add_word(1, 32'hAAAA0001, 1'b0);
    add_word(1, 32'hAAAA0002, 1'b0);
    add_word(1, 32'hAAAA0003, 1'b1);
    expect_word(32'hA5010000, 4'b0000);
    expect_word(32'hAAAA0001, 4'b0010);
    expect_word(32'hAAAA0002, 4'b0010);
    expect_word(32'hAAAA0003, 4'b0010);
    expect_word(32'h5A010003, 4'b0000);
    wait_ack(1, base + 1);
    @(negedge clk);
    add_word(2, 32'hBBBB0001, 1'b1);
    expect_word(32'hA5020000, 4'b0000);
    expect_word(32'hBBBB0001, 4'b0100);
    expect_word(32'h5A020001, 4'b0000);
    wait_drain("no_preempt");

    // Timeout: req3 sends one word without last, then goes quiet.
    add_word(3, 32'hDEADBEEF, 1'b0);
    expect_word(32'hA5030000, 4'b0000);
    expect_word(32'hDEADBEEF, 4'b1000);
    expect_word(32'h5A830001, 4'b0000);
    wait_drain("timeout");
    check("timeout_count", 32'(tmo_count), 32'd1);
    check("timeout_delay", 32'(tmo_cyc - ack_cyc[3]), 32'd16);

    // Holdoff: ready tied high, strobes must still be spaced.
    ready_tied = 1'b1;
    add_word(0, 32'hCCCC0001, 1'b0);
    add_word(0, 32'hCCCC0002, 1'b0);
    add_word(0, 32'hCCCC0003, 1'b1);
    expect_word(32'hA5000000, 4'b0000);
    expect_word(32'hCCCC0001, 4'b0001);
    expect_word(32'hCCCC0002, 4'b0001);
    expect_word(32'hCCCC0003, 4'b0001);
    expect_word(32'h5A000003, 4'b0000);
    wait_drain("holdoff");
    ready_tied = 1'b0;
    @(negedge clk);

    // Reset during DATA: no trailer, then requester 0 wins first.
    base = ack_cnt[0];
    add_word(0, 32'hEEEE0001, 1'b0);
    add_word(0, 32'hEEEE0002, 1'b0);
    add_word(0, 32'hEEEE0003, 1'b1);
    expect_word(32'hA5000000, 4'b0000);
    expect_word(32'hEEEE0001, 4'b0001);
    wait_ack(0, base + 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_tx_strobe", 32'(tx_strobe), 32'd0);
    check("midrst_tx_data", tx_data, 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_ack", 32'(req_ack), 32'd0);
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    add_word(1, 32'h77770001, 1'b1);
    add_word(0, 32'h66660001, 1'b1);
    expect_word(32'hA5000000, 4'b0000);
    expect_word(32'h66660001, 4'b0001);
    expect_word(32'h5A000001, 4'b0000);
    expect_word(32'hA5010000, 4'b0000);
    expect_word(32'h77770001, 4'b0010);
    expect_word(32'h5A010001, 4'b0000);
    wait_drain("after_reset");
    check("final_timeout_count", 32'(tmo_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
